fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The module SHALL have parameter RESET_PC, default 64'h0, meaning the first fetch address after reset.
REQ-002 The module SHALL have parameter FIFO_DEPTH, default 4, meaning instruction-buffer entries and the maximum number of outstanding requests; legal values are a power of 2 and at least 2.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 The module SHALL have port imem_req_valid, output, 1 bit: a fetch request is presented.
REQ-006 The module SHALL have port imem_req_ready, input, 1 bit: memory accepts the request.
REQ-007 The module SHALL have port imem_req_addr, output, 64 bits: fetch address, always 4-byte aligned.
REQ-008 The module SHALL have port imem_rsp_valid, input, 1 bit: response data valid; responses return in request order, at least 1 cycle after acceptance.
REQ-009 The module SHALL have port imem_rsp_data, input, 32 bits: instruction word.
REQ-010 The module SHALL have port redirect_valid, input, 1 bit: single-cycle pulse requesting a fetch redirect (branch, jump or trap).
REQ-011 The module SHALL have port redirect_pc, input, 64 bits: new fetch address; bits [1:0] are ignored.
REQ-012 The module SHALL have port inst_valid, output, 1 bit: instruction available to the downstream execute stage.
REQ-013 The module SHALL have port inst_ready, input, 1 bit: execute stage accepts the instruction.
REQ-014 The module SHALL have port inst_data, output, 32 bits: instruction word.
REQ-015 The module SHALL have port inst_pc, output, 64 bits: address of inst_data.

Function
REQ-016 A request handshake (imem_req_valid and imem_req_ready high) SHALL advance fetch_pc by 4, modulo 2^64, so that 64'hFFFF_FFFF_FFFF_FFFC wraps to 0.
REQ-017 imem_req_valid SHALL be high only when outstanding + fifo_count < FIFO_DEPTH and redirect_valid is low, so that responses never overflow the buffer.
REQ-018 imem_req_addr SHALL equal fetch_pc and SHALL stay stable while imem_req_valid is high and imem_req_ready is low; only a redirect may change or withdraw the request.
REQ-019 Each accepted request SHALL push its address into an in-order address queue; each imem_rsp_valid SHALL pop that queue and write {addr, data} into the FIFO.
REQ-020 Response-to-output latency SHALL be 1 cycle: inst_valid is registered, with no bypass from imem_rsp_valid.
REQ-021 inst_valid SHALL equal FIFO not-empty; inst_data and inst_pc SHALL show the FIFO head; a handshake with inst_valid and inst_ready high pops the head.
REQ-022 A simultaneous push and pop on a full FIFO SHALL NOT occur, per REQ-017; a simultaneous push and pop on a non-empty FIFO SHALL keep the count unchanged.
REQ-023 On redirect_valid, the FIFO SHALL be flushed (inst_valid low the next cycle), and fetch_pc SHALL become {redirect_pc[63:2], 2'b00}, presented on imem_req_addr the next cycle.
REQ-024 On redirect_valid, drop_count SHALL be loaded with the outstanding requests, including any handshaking that cycle; the next drop_count responses SHALL be discarded, and a response arriving in the redirect cycle SHALL count as discarded.
REQ-025 Redirect SHALL take priority over a same-cycle inst handshake, a response write, or a FIFO pop; a head popped in that cycle still counts as consumed.
REQ-026 outstanding SHALL increment on request accept, decrement on any response (kept or dropped), and be unchanged when both occur in the same cycle.

Reset
REQ-027 While rst is high: fetch_pc = RESET_PC, FIFO empty, outstanding = 0, drop_count = 0, imem_req_valid = 0, inst_valid = 0, inst_data = 0, inst_pc = 0.
REQ-028 The first request SHALL be presented in the first cycle after rst deasserts; responses in flight across reset SHALL be ignored, with memory reset together with this block.

Structure
REQ-029 Package fetch_pkg SHALL hold the XLEN = 64 and ILEN = 32 constants and a packed typedef fetch_entry_t {pc, inst}.
REQ-030 Sub-module fetch_fifo SHALL implement the parameterized synchronous FIFO of fetch_entry_t, with flush input, full and empty flags, and count; the address queue may reuse it.

Verification
REQ-031 Reset release, 1-cycle memory, inst_ready held 1 -> inst_pc sequence 0x0, 0x4, 0x8, 0xC; first inst_valid 2 cycles after first accept.
REQ-032 inst_ready held 0 -> exactly FIFO_DEPTH (4) requests accepted, then imem_req_valid stays 0; raising inst_ready resumes fetch at 0x10.
REQ-033 Redirect to 0x1003 with 3 outstanding requests -> next imem_req_addr = 0x1000, 3 responses dropped, first inst_pc = 0x1000.
REQ-034 RESET_PC = 64'hFFFF_FFFF_FFFF_FFF8 -> inst_pc sequence ...FFF8, ...FFFC, 0x0.
REQ-035 Redirect in the same cycle as a response and an inst handshake -> response dropped, FIFO empty next cycle, no duplicate or lost PCs afterwards.
REQ-036 Assert rst mid-stream with 2 outstanding requests -> all outputs zero immediately; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths and the instruction-buffer entry type for the
// fetch unit.
//   XLEN          - address width
//   ILEN          - instruction width
//   fetch_entry_t - packed {pc, inst} pair held in the instruction buffer
//   align_pc()    - clears bits [1:0] so a fetch address is word aligned
package fetch_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 32;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] inst;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
        return pc & ~XLEN'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction-memory and execute-stage handshakes of the
// fetch unit.
//   imem_req_*     - fetch request to memory (valid/ready, address)
//   imem_rsp_*     - in-order response from memory (valid, data)
//   redirect_*     - single-cycle fetch redirect (valid, target pc)
//   inst_*         - instruction stream to execute (valid/ready, data, pc)
// Modports: master = fetch unit side, slave = memory / execute side.
interface fetch_unit_if;
    import fetch_pkg::*;

    logic            imem_req_valid;
    logic            imem_req_ready;
    logic [XLEN-1:0] imem_req_addr;
    logic            imem_rsp_valid;
    logic [ILEN-1:0] imem_rsp_data;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            inst_valid;
    logic            inst_ready;
    logic [ILEN-1:0] inst_data;
    logic [XLEN-1:0] inst_pc;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
               redirect_valid, redirect_pc, inst_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO of fetch_entry_t with flush.
//   clk, rst     - clock, asynchronous active-high reset
//   i_flush      - empties the FIFO; wins over push and pop
//   i_push       - write i_push_data (accepted when not full, or full with pop)
//   i_pop        - drop the head (ignored when empty)
//   o_head       - current head, zero when empty
//   o_full       - DEPTH entries held
//   o_empty      - no entries held
//   o_count      - number of entries held
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  fetch_entry_t             i_push_data,
    input  logic                     i_pop,
    output fetch_entry_t             o_head,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int unsigned AW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [AW-1:0] r_wptr;
    logic [AW-1:0] r_rptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    always_comb begin
        o_full  = (r_count == (AW+1)'(DEPTH));
        o_empty = (r_count == '0);
        w_pop   = i_pop && !o_empty;
        w_push  = i_push && (!o_full || w_pop);
        o_count = r_count;
        o_head  = o_empty ? '0 : r_mem[r_rptr];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            r_count <= r_count + (AW+1)'(w_push) - (AW+1)'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push && !i_flush) r_mem[r_wptr] <= i_push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction fetch with an in-order response buffer
// and redirect support.
//   clk, rst       - clock, asynchronous active-high reset
//   bus (master)   - imem request/response, redirect and instruction stream
// Parameters:
//   RESET_PC       - first fetch address after reset
//   FIFO_DEPTH     - buffer entries and maximum outstanding requests
//                    (power of 2, >= 2)
module fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC   = 64'h0,
    parameter int unsigned     FIFO_DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fetch_unit_if.master  bus
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [XLEN-1:0] r_fetch_pc;
    logic [CW-1:0]   r_outstanding;
    logic [CW-1:0]   r_drop_count;
    logic [XLEN-1:0] r_aq_mem [FIFO_DEPTH];
    logic [AW-1:0]   r_aq_wptr;
    logic [AW-1:0]   r_aq_rptr;

    logic            w_redirect;
    logic [XLEN-1:0] w_redirect_pc;
    logic [CW:0]     w_inflight;
    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_rsp;
    logic            w_rsp_drop;
    logic            w_rsp_keep;
    logic            w_inst_pop;
    logic [CW-1:0]   w_outstanding_next;
    fetch_entry_t    w_push_entry;
    fetch_entry_t    w_head;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic [CW-1:0]   w_fifo_count;

    always_comb begin
        w_redirect    = bus.redirect_valid;
        w_redirect_pc = align_pc(bus.redirect_pc);
        // Every outstanding request reserves a buffer slot, so a response
        // always finds room.
        w_inflight    = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
        w_req_valid   = !rst && !w_redirect && !w_fifo_full &&
                        (w_inflight < (CW+1)'(FIFO_DEPTH));
        w_req_fire    = w_req_valid && bus.imem_req_ready;
        // A response with nothing outstanding is stale and ignored.
        w_rsp         = bus.imem_rsp_valid && (r_outstanding != '0);
        w_rsp_drop    = w_rsp && (r_drop_count != '0);
        // In a redirect cycle the flush discards this write.
        w_rsp_keep    = w_rsp && !w_rsp_drop;
        w_inst_pop    = !w_fifo_empty && bus.inst_ready;
        w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp);
        w_push_entry.pc   = r_aq_mem[r_aq_rptr];
        w_push_entry.inst = bus.imem_rsp_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc    <= align_pc(RESET_PC);
            r_outstanding <= '0;
            r_drop_count  <= '0;
            r_aq_wptr     <= '0;
            r_aq_rptr     <= '0;
        end else begin
            r_outstanding <= w_outstanding_next;
            if (w_redirect) begin
                // Everything still in flight after this cycle belongs to the
                // old path; the address queue is emptied since those
                // responses are never written.
                r_fetch_pc   <= w_redirect_pc;
                r_drop_count <= w_outstanding_next;
                r_aq_wptr    <= '0;
                r_aq_rptr    <= '0;
            end else begin
                if (w_req_fire) begin
                    r_fetch_pc <= r_fetch_pc + XLEN'(4);
                    r_aq_wptr  <= r_aq_wptr + 1'b1;
                end
                if (w_rsp_drop) r_drop_count <= r_drop_count - 1'b1;
                if (w_rsp_keep) r_aq_rptr <= r_aq_rptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_req_fire) r_aq_mem[r_aq_wptr] <= r_fetch_pc;
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_flush     (w_redirect),
        .i_push      (w_rsp_keep),
        .i_push_data (w_push_entry),
        .i_pop       (w_inst_pop),
        .o_head      (w_head),
        .o_full      (w_fifo_full),
        .o_empty     (w_fifo_empty),
        .o_count     (w_fifo_count)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_fetch_pc;
    assign bus.inst_valid     = !w_fifo_empty;
    assign bus.inst_data      = w_head.inst;
    assign bus.inst_pc        = w_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized bench for fetch_unit against a program-order
// reference model (next request address, next delivered pc, memory queue).
module tb_fetch_unit;
    import fetch_pkg::*;

    localparam int unsigned DEPTH  = 4;
    localparam logic [63:0] RST_PC = 64'h0;

    logic clk;
    logic rst;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if bus();
    fetch_unit_if bus_w();

    fetch_unit #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );

    fetch_unit #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFF8), .FIFO_DEPTH(DEPTH)) dut_w (
        .clk (clk), .rst (rst), .bus (bus_w)
    );

    int n_checks = 0;
    int n_pass   = 0;

    logic [63:0] mq_addr[$];
    int          mq_cyc[$];
    logic [63:0] exp_req_pc, exp_inst_pc, first_pc;
    int          tb_out, cyc, n_deliv, n_fire;
    bit          after_redir, prev_stall, started, wrap_done;
    logic        s_req_valid, s_inst_valid, s_fire;
    logic [63:0] s_req_addr, s_inst_pc;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: observed %h, expected %h", tag, act, exp);
    endtask

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'h5EED_1234;
    endfunction

    task automatic do_reset(input bit immediate);
        rst = 1'b1;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        if (!immediate) @(posedge clk);
        #1;
        chk("rst_req_valid", 64'(bus.imem_req_valid), 64'd0);
        chk("rst_req_addr",  bus.imem_req_addr, RST_PC);
        chk("rst_inst_valid", 64'(bus.inst_valid), 64'd0);
        chk("rst_inst_data", 64'(bus.inst_data), 64'd0);
        chk("rst_inst_pc",   bus.inst_pc, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rel_req_valid", 64'(bus.imem_req_valid), 64'd1);
        chk("rel_req_addr",  bus.imem_req_addr, RST_PC);
        mq_addr.delete();
        mq_cyc.delete();
        exp_req_pc  = RST_PC;
        exp_inst_pc = RST_PC;
        first_pc    = '1;
        tb_out = 0; cyc = 0; n_deliv = 0; n_fire = 0;
        after_redir = 1'b0;
        prev_stall  = 1'b0;
    endtask

    // One cycle: drive inputs after the falling edge, sample, and advance the
    // model by what will happen at the next rising edge.
    task automatic step(input bit req_rdy, input bit rsp_en, input bit inst_rdy,
                        input bit redir, input logic [63:0] rpc);
        logic [63:0] a;
        bit rsp;
        @(negedge clk);
        rsp = 1'b0;
        a   = '0;
        if (rsp_en && mq_addr.size() > 0) begin
            if (mq_cyc[0] < cyc) begin
                rsp = 1'b1;
                a   = mq_addr.pop_front();
                void'(mq_cyc.pop_front());
            end
        end
        bus.imem_rsp_valid = rsp;
        bus.imem_rsp_data  = rsp ? mem_word(a) : 32'($urandom);
        bus.imem_req_ready = req_rdy;
        bus.inst_ready     = inst_rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = rpc;
        #1;
        s_req_valid  = bus.imem_req_valid;
        s_req_addr   = bus.imem_req_addr;
        s_inst_valid = bus.inst_valid;
        s_inst_pc    = bus.inst_pc;
        s_fire       = s_req_valid && req_rdy;
        if (after_redir) begin
            chk("flush_valid", 64'(s_inst_valid), 64'd0);
            chk("redir_addr", s_req_addr, exp_req_pc);
        end
        if (prev_stall && !redir) chk("req_hold", 64'(s_req_valid), 64'd1);
        if (redir) chk("req_gate", 64'(s_req_valid), 64'd0);
        if (s_req_valid) chk("req_addr", s_req_addr, exp_req_pc);
        if (s_inst_valid) chk("inst_data", 64'(bus.inst_data), 64'(mem_word(s_inst_pc)));
        if (s_inst_valid && inst_rdy) begin
            chk("inst_pc", s_inst_pc, exp_inst_pc);
            if (n_deliv == 0) first_pc = s_inst_pc;
            exp_inst_pc += 64'd4;
            n_deliv++;
        end
        if (s_fire) begin
            chk("max_out", 64'(tb_out < int'(DEPTH)), 64'd1);
            mq_addr.push_back(s_req_addr);
            mq_cyc.push_back(cyc);
            exp_req_pc += 64'd4;
            tb_out++;
            n_fire++;
        end
        if (rsp) tb_out--;
        prev_stall = s_req_valid && !req_rdy;
        if (redir) begin
            exp_req_pc  = rpc & ~64'h3;
            exp_inst_pc = exp_req_pc;
        end
        after_redir = redir;
        cyc++;
    endtask

    // Second instance: wrap of the fetch address from a high RESET_PC.
    initial begin
        logic [63:0] wq[$];
        logic [63:0] wexp;
        int wn;
        bus_w.imem_req_ready = 1'b0;
        bus_w.imem_rsp_valid = 1'b0;
        bus_w.imem_rsp_data  = '0;
        bus_w.inst_ready     = 1'b0;
        bus_w.redirect_valid = 1'b0;
        bus_w.redirect_pc    = '0;
        wait (started);
        wexp = 64'hFFFF_FFFF_FFFF_FFF8;
        wn   = 0;
        for (int i = 0; i < 30 && wn < 3; i++) begin
            @(negedge clk);
            bus_w.imem_req_ready = 1'b1;
            bus_w.inst_ready     = 1'b1;
            if (wq.size() > 0) begin
                bus_w.imem_rsp_valid = 1'b1;
                bus_w.imem_rsp_data  = mem_word(wq.pop_front());
            end else begin
                bus_w.imem_rsp_valid = 1'b0;
                bus_w.imem_rsp_data  = '0;
            end
            #1;
            if (bus_w.inst_valid) begin
                chk("wrap_pc", bus_w.inst_pc, wexp);
                wexp += 64'd4;
                wn++;
            end
            if (bus_w.imem_req_valid) wq.push_back(bus_w.imem_req_addr);
        end
        chk("wrap_count", 64'(wn), 64'd3);
        bus_w.imem_req_ready = 1'b0;
        bus_w.imem_rsp_valid = 1'b0;
        wrap_done = 1'b1;
    end

    initial begin
        logic [63:0] rpc;
        bit redir;
        bit got;
        int d0;

        // Reset release, 1-cycle memory, consumer always ready.
        do_reset(1'b0);
        started = 1'b1;
        step(1, 1, 1, 0, '0);
        chk("first_accept", 64'(s_fire), 64'd1);
        step(1, 1, 1, 0, '0);
        chk("lat_cyc1", 64'(s_inst_valid), 64'd0);
        step(1, 1, 1, 0, '0);
        chk("lat_cyc2", 64'(s_inst_valid), 64'd1);
        chk("first_pc", s_inst_pc, RST_PC);
        repeat (5) step(1, 1, 1, 0, '0);
        chk("stream_count", 64'(n_deliv), 64'd6);

        // Consumer stalled: buffer fills, then fetch resumes at 0x10.
        do_reset(1'b0);
        repeat (12) step(1, 1, 0, 0, '0);
        chk("stall_fires", 64'(n_fire), 64'(DEPTH));
        chk("stall_idle", 64'(s_req_valid), 64'd0);
        got = 1'b0;
        for (int i = 0; i < 10 && !got; i++) begin
            step(1, 1, 1, 0, '0);
            if (s_fire) begin
                got = 1'b1;
                chk("resume_addr", s_req_addr, 64'h10);
            end
        end
        chk("resume_fire", 64'(got), 64'd1);

        // Redirect to 0x1003 with three requests in flight.
        do_reset(1'b0);
        repeat (3) step(1, 0, 1, 0, '0);
        chk("out3", 64'(tb_out), 64'd3);
        step(1, 0, 1, 1, 64'h1003);
        n_deliv = 0;
        repeat (20) step(1, 1, 1, 0, '0);
        chk("redir_first_pc", first_pc, 64'h1000);

        // Redirect coinciding with a response and an instruction handshake.
        repeat (6) step(1, 1, 1, 0, '0);
        step(1, 1, 1, 1, 64'h2000);
        chk("coincide_hs", 64'(s_inst_valid), 64'd1);
        n_deliv = 0;
        repeat (15) step(1, 1, 1, 0, '0);
        chk("coincide_first_pc", first_pc, 64'h2000);

        // Randomized traffic with occasional redirects.
        d0 = n_deliv;
        for (int i = 0; i < 1500; i++) begin
            redir = ($urandom_range(39) == 0);
            rpc   = {$urandom, $urandom};
            if ($urandom_range(3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(15));
            step($urandom_range(3) != 0, $urandom_range(3) != 0,
                 $urandom_range(2) != 0, redir, rpc);
        end
        chk("rand_progress", 64'(n_deliv > d0), 64'd1);

        // Reset mid-stream with two requests outstanding and a buffered entry.
        for (int i = 0; i < 40 && tb_out != 0; i++) step(0, 1, 1, 0, '0);
        chk("drain", 64'(tb_out), 64'd0);
        repeat (3) step(1, 0, 0, 0, '0);
        step(0, 1, 0, 0, '0);
        step(0, 0, 0, 0, '0);
        chk("pre_rst_valid", 64'(s_inst_valid), 64'd1);
        chk("pre_rst_out", 64'(tb_out), 64'd2);
        do_reset(1'b1);
        repeat (10) step(1, 1, 1, 0, '0);
        chk("restart_pc", first_pc, RST_PC);

        for (int i = 0; i < 100 && !wrap_done; i++) @(negedge clk);
        chk("wrap_done", 64'(wrap_done), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
